freq_meter: RTL and testbench

- Measures an external periodic signal (slow/divided clock, sensor pulse train) in units of i_clk cycles.
- Reports period and high time once per input period, with a one-cycle valid strobe.
- Flags loss of signal with a timeout.
- Sits on the receive side of a divided-clock link; it is the consumer/checker of a frequency-divider output.

---
 rtl/freq_meter_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 33 +++
 rtl/freq_meter.sv | 161 ++++++++++++++++
 tb/tb_freq_meter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter shared types: FSM state, averaging depth and
// accumulator width helper.
package freq_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } fm_state_e;

  // log2 of the number of periods averaged when averaging is built in
  localparam int AVG_LOG2 = 2;

  function automatic int acc_width(input int cnt_w);
    return cnt_w + AVG_LOG2;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus registered copy; emits level and
// single-cycle rise/fall pulses. Ports: i_clk, i_reset_n, i_async,
// o_level, o_rise, o_fall.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign o_level = sync_q;
  assign o_rise  = sync_q & ~dly_q;
  assign o_fall  = ~sync_q & dly_q;

endmodule

// File: rtl/freq_meter.sv
// Period / high-time meter for an asynchronous input, in i_clk cycles,
// with sticky loss-of-signal timeout.
// Ports: i_clk, i_reset_n (async, active-low), i_signal;
// o_period, o_high_time, o_valid (1-cycle strobe), o_timeout (sticky).
// Optional: FREQ_METER_AVG_EN reports the mean of 4 measurements.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_signal,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_valid,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic lvl_unused;
  logic rise;
  logic fall;

  sync_edge_det u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_signal),
    .o_level   (lvl_unused),
    .o_rise    (rise),
    .o_fall    (fall)
  );

  fm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hlat_q, hlat_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;

`ifdef FREQ_METER_AVG_EN
  localparam int ACC_W = acc_width(CNT_W);
  localparam logic [AVG_LOG2-1:0] IDX_ONE =
    {{(AVG_LOG2-1){1'b0}}, 1'b1};

  logic [ACC_W-1:0]    sp_q, sp_d, sp_n;
  logic [ACC_W-1:0]    sh_q, sh_d, sh_n;
  logic [AVG_LOG2-1:0] idx_q, idx_d;

  assign sp_n = sp_q + {{AVG_LOG2{1'b0}}, cnt_q};
  assign sh_n = sh_q + {{AVG_LOG2{1'b0}}, hlat_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hlat_d  = hlat_q;
    per_d   = per_q;
    high_d  = high_q;
    vld_d   = 1'b0;
    to_d    = to_q;
`ifdef FREQ_METER_AVG_EN
    sp_d    = sp_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = ONE_C;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          cnt_d = ONE_C;
          to_d  = 1'b0;
`ifdef FREQ_METER_AVG_EN
          if (idx_q == '1) begin
            per_d  = sp_n[ACC_W-1:AVG_LOG2];
            high_d = sh_n[ACC_W-1:AVG_LOG2];
            vld_d  = 1'b1;
            sp_d   = '0;
            sh_d   = '0;
            idx_d  = '0;
          end else begin
            sp_d  = sp_n;
            sh_d  = sh_n;
            idx_d = idx_q + IDX_ONE;
          end
`else
          per_d  = cnt_q;
          high_d = hlat_q;
          vld_d  = 1'b1;
`endif
        end else if (cnt_q == TO_C) begin
          // lost signal: outputs keep last measurement
          to_d    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
`ifdef FREQ_METER_AVG_EN
          sp_d    = '0;
          sh_d    = '0;
          idx_d   = '0;
`endif
        end else begin
          if (fall) hlat_d = cnt_q;
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hlat_q  <= '0;
      per_q   <= '0;
      high_q  <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hlat_q  <= hlat_d;
      per_q   <= per_d;
      high_q  <= high_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end

`ifdef FREQ_METER_AVG_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sp_q  <= '0;
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sp_q  <= sp_d;
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end
`endif

  assign o_period    = per_q;
  assign o_high_time = high_q;
  assign o_valid     = vld_q;
  assign o_timeout   = to_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: event-time reference model checked every
// cycle, plus literal expectations at the end of each phase.
module tb_freq_meter;

  localparam int CW = 16;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sig;
  logic [CW-1:0] o_period;
  logic [CW-1:0] o_high_time;
  logic          o_valid;
  logic          o_timeout;

  freq_meter #(
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_signal    (sig),
    .o_period    (o_period),
    .o_high_time (o_high_time),
    .o_valid     (o_valid),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int vcount   = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model. The input seen at a negedge becomes visible on
  // the outputs three negedges later (sync + edge detect + register).
  // Periods / high times are differences of edge times.
  logic h [5];
  int   t;
  int   last_rise;
  bit   armed;
  int   m_hl;
  int   m_per;
  int   m_high;
  bit   m_vld;
  bit   m_to;
  int   n_acc;
  int   s_per;
  int   s_high;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) h[i] = 1'b0;
      t = 0; last_rise = 0; armed = 0; m_hl = 0;
      m_per = 0; m_high = 0; m_vld = 0; m_to = 0;
      n_acc = 0; s_per = 0; s_high = 0;
    end else begin
      for (int i = 4; i > 0; i--) h[i] = h[i-1];
      h[0] = sig;
      t++;
      m_vld = 0;
      if (h[3] && !h[4]) begin
        if (armed) begin
          m_to = 0;
`ifdef FREQ_METER_AVG_EN
          s_per  += t - last_rise;
          s_high += m_hl;
          n_acc++;
          if (n_acc == 4) begin
            m_per  = s_per / 4;
            m_high = s_high / 4;
            m_vld  = 1;
            n_acc = 0; s_per = 0; s_high = 0;
          end
`else
          m_per  = t - last_rise;
          m_high = m_hl;
          m_vld  = 1;
`endif
        end
        armed     = 1;
        last_rise = t;
      end else if (armed && (t - last_rise == TO)) begin
        m_to  = 1;
        armed = 0;
        n_acc = 0; s_per = 0; s_high = 0;
      end else if (!h[3] && h[4] && armed) begin
        m_hl = t - last_rise;
      end
    end
    check("valid",   32'(o_valid),     32'(m_vld));
    check("timeout", 32'(o_timeout),   32'(m_to));
    check("period",  32'(o_period),    32'(m_per));
    check("high",    32'(o_high_time), 32'(m_high));
    if (o_valid === 1'b1) vcount++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_wave(input int p, input int hi, input int n);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < p; c++) begin
        sig = (c < hi);
        tick(1);
      end
  endtask

  initial begin
    rst_n = 1'b0;
    sig   = 1'b0;
    tick(2);
    check("rst_period",  32'(o_period),    0);
    check("rst_high",    32'(o_high_time), 0);
    check("rst_valid",   32'(o_valid),     0);
    check("rst_timeout", 32'(o_timeout),   0);
    tick(1);
    rst_n = 1'b1;

    // 4-cycle 50% square wave
    vcount = 0;
    run_wave(4, 2, 6);
`ifdef FREQ_METER_AVG_EN
    check("sq4_vcount", 32'(vcount), 1);
`else
    check("sq4_vcount", 32'(vcount), 5);
`endif
    check("sq4_period",  32'(o_period),    4);
    check("sq4_high",    32'(o_high_time), 2);
    check("sq4_timeout", 32'(o_timeout),   0);

    run_wave(10, 3, 3);
`ifndef FREQ_METER_AVG_EN
    check("p10_period", 32'(o_period),    10);
    check("p10_high",   32'(o_high_time), 3);
`endif
    run_wave(6, 1, 3);
`ifndef FREQ_METER_AVG_EN
    check("p6_period", 32'(o_period),    6);
    check("p6_high",   32'(o_high_time), 1);
`endif

    // loss of signal, held low
    sig = 1'b0;
    tick(60);
    check("lo_timeout", 32'(o_timeout), 1);
`ifndef FREQ_METER_AVG_EN
    check("lo_period_kept", 32'(o_period), 6);
`endif

    // restart: first rise only re-arms
    vcount = 0;
    run_wave(8, 4, 1);
    check("rearm_vcount",  32'(vcount),    0);
    check("rearm_timeout", 32'(o_timeout), 1);
    run_wave(8, 4, 1);
    tick(4);
    check("restart_timeout", 32'(o_timeout), 0);
`ifndef FREQ_METER_AVG_EN
    check("restart_period", 32'(o_period),    8);
    check("restart_high",   32'(o_high_time), 4);
`endif

    // stuck high after a timeout
    tick(60);
    vcount = 0;
    sig = 1'b1;
    tick(70);
    check("stuck_vcount",  32'(vcount),    0);
    check("stuck_timeout", 32'(o_timeout), 1);
    sig = 1'b0;

    // asynchronous reset in the middle of a period
    run_wave(5, 2, 3);
`ifndef FREQ_METER_AVG_EN
    check("p5_period", 32'(o_period), 5);
`endif
    sig = 1'b1;
    tick(1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_period",  32'(o_period),    0);
    check("arst_high",    32'(o_high_time), 0);
    check("arst_valid",   32'(o_valid),     0);
    check("arst_timeout", 32'(o_timeout),   0);
    tick(3);
    rst_n = 1'b1;
    sig   = 1'b0;
    vcount = 0;
    run_wave(7, 3, 3);
    tick(4);
`ifndef FREQ_METER_AVG_EN
    check("post_rst_vcount", 32'(vcount),      2);
    check("post_rst_period", 32'(o_period),    7);
    check("post_rst_high",   32'(o_high_time), 3);
`endif

    // periods 4,4,6,6 after a fresh reset
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    vcount = 0;
    run_wave(4, 2, 2);
    run_wave(6, 3, 2);
    sig = 1'b1;
    tick(1);
    sig = 1'b0;
    tick(5);
`ifdef FREQ_METER_AVG_EN
    check("mix_vcount", 32'(vcount),      1);
    check("mix_period", 32'(o_period),    5);
    check("mix_high",   32'(o_high_time), 2);
`else
    check("mix_vcount", 32'(vcount),      4);
    check("mix_period", 32'(o_period),    6);
    check("mix_high",   32'(o_high_time), 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
